// File: rtl/mask_mem_arbiter.sv
// rtl/mask_mem_arbiter.sv - Single-port mask RAM arbiter: video reads first, loader writes through a 2-deep FIFO.
module mask_mem_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 40,
    parameter int MAX_WORDS  = 18720
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ioctl_download,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  loaded,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MAX_W = CW'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    state_t                state_q, state_d;
    logic                  dl_q;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  head_q;
    logic [1:0]            count_q;
    logic [CW-1:0]         wc_q;
    logic                  ovf_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_hold_q;

    logic rise, start, push, pop, wr_grant;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        rise     = ioctl_download & ~dl_q;
        unique case (state_q)
            IDLE:  if (rise) state_d = LOAD;
            LOAD:  if (!ioctl_download) state_d = FLUSH;
            FLUSH: begin
                // A restart seen while draining is remembered and honoured once in RUN.
                if (rise) pend_d = 1'b1;
                if (count_q == 2'd0) state_d = RUN;
            end
            RUN: begin
                pend_d = 1'b0;
                if (rise || (pend_q && ioctl_download)) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
        start    = (state_d == LOAD) && (state_q != LOAD);

        wr_ready = (state_q == LOAD) && (count_q != 2'd2);
        push     = wr_valid & wr_ready;
        pop      = ~rd_req & (count_q != 2'd0);
        wr_grant = pop & (wc_q < MAX_W);

        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        if (rd_req) begin
            mem_address = rd_addr;
        end else if (wr_grant) begin
            mem_wren    = 1'b1;
            mem_address = wc_q[ADDR_WIDTH-1:0];
            mem_data    = fifo_q[head_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            dl_q       <= 1'b0;
            pend_q     <= 1'b0;
            head_q     <= 1'b0;
            count_q    <= 2'd0;
            wc_q       <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            dl_q       <= ioctl_download;
            pend_q     <= pend_d;
            rd_valid_q <= rd_req;
            if (rd_valid_q) rd_hold_q <= mem_q;
            if (start) begin
                head_q  <= 1'b0;
                count_q <= 2'd0;
                wc_q    <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (push) fifo_q[head_q ^ count_q[0]] <= wr_data;
                count_q <= count_q + {1'b0, push} - {1'b0, pop};
                head_q  <= head_q ^ pop;
                if (wr_grant) wc_q <= wc_q + 1'b1;
                if (pop && !wr_grant) ovf_q <= 1'b1;
            end
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_valid_q ? mem_q : rd_hold_q;
    assign loaded     = (state_q == RUN);
    assign word_count = wc_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/mask_mem_arbiter.md
MASK_MEM_ARBITER -- requirements
Module: mask_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, mask memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 40, mask entry width.
REQ-003 SHALL have parameter MAX_WORDS, default 18720, number of writable entries.
REQ-004 SHALL have ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ioctl_download  in  1  download window active.
- wr_valid  in  1  loader offers a packed entry.
- wr_data  in  DATA_WIDTH  packed entry.
- wr_ready  out  1  arbiter accepts the entry this cycle.
- rd_req  in  1  video read request.
- rd_addr  in  ADDR_WIDTH  video read address.
- rd_valid  out  1  rd_data valid.
- rd_data  out  DATA_WIDTH  read result.
- mem_address  out  ADDR_WIDTH  single-port RAM address.
- mem_wren  out  1  RAM write enable.
- mem_data  out  DATA_WIDTH  RAM write data.
- mem_q  in  DATA_WIDTH  RAM registered read data; 1-cycle latency.
- loaded  out  1  complete image resident.
- word_count  out  ADDR_WIDTH+1  entries written this download.
- overflow  out  1  sticky; entries beyond MAX_WORDS were offered.

Function
REQ-005 SHALL implement states IDLE, LOAD, FLUSH, RUN; reset state IDLE.
REQ-006 SHALL go IDLE->LOAD and RUN->LOAD on the cycle ioctl_download is first sampled high (rising edge).
REQ-007 On entry to LOAD: write pointer=0, word_count=0, loaded=0, overflow=0, FIFO emptied.
REQ-008 SHALL go LOAD->FLUSH when ioctl_download is sampled low.
REQ-009 SHALL go FLUSH->RUN on the cycle the FIFO is observed empty; loaded=1 from the following cycle until next LOAD entry or reset.
REQ-010 SHALL buffer loader entries in a 2-entry FIFO; wr_ready=1 only in LOAD with FIFO count<2; handshake = wr_valid & wr_ready.
REQ-011 wr_ready SHALL be 0 in IDLE, FLUSH and RUN; wr_valid there is ignored.
REQ-012 Port priority in every state: video read first; FIFO drain only in cycles with rd_req=0.
REQ-013 Read grant (rd_req=1): mem_address=rd_addr, mem_wren=0, same cycle (combinational).
REQ-014 rd_valid SHALL be 1 exactly one cycle after each rd_req=1 cycle, with rd_data=mem_q in that cycle; else rd_valid=0, rd_data holds its last value.
REQ-015 Write grant (rd_req=0, FIFO non-empty, pointer<MAX_WORDS): mem_address=pointer, mem_data=FIFO head, mem_wren=1; pop; pointer+1; word_count+1.
REQ-016 Head popped with pointer==MAX_WORDS: discard, mem_wren=0, overflow=1, pointer and word_count unchanged.
REQ-017 No grant: mem_wren=0, mem_address=0, mem_data=0.
REQ-018 Push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-019 FIFO order SHALL be preserved; no entry lost or duplicated while rd_req stalls draining for any duration.
REQ-020 Download restart (LOAD entry) during FLUSH is not possible; rising edge during FLUSH is only acted on after reaching RUN, if ioctl_download is still high.
REQ-021 Arbiter SHALL never write and read in the same cycle.

Reset
REQ-022 reset_n=0 at a rising edge: state IDLE, FIFO empty, pointer=0, wr_ready=0, rd_valid=0, rd_data=0, loaded=0, word_count=0, overflow=0, mem_wren=0, from the next cycle.
REQ-023 Reset mid-LOAD or mid-FLUSH SHALL abandon buffered entries; no further mem_wren until a new download.
REQ-024 Edge detector for ioctl_download SHALL reset to 0; download high at reset release counts as a rising edge.

Verification
REQ-025 Download 3 entries 0x01..0x03 with rd_req=0 -> mem_wren at addresses 0,1,2 in order, word_count=3, loaded=1 after FLUSH.
REQ-026 rd_req=1, rd_addr=0x0005 during LOAD with FIFO holding 2 entries for 10 cycles -> wr_ready=0, no mem_wren for 10 cycles, then both entries written to consecutive addresses.
REQ-027 Back-to-back rd_req at addresses 7,8 in RUN -> rd_valid high on the next two cycles with rd_data = mem_q of 7 then 8.
REQ-028 MAX_WORDS=4, offer 6 entries -> 4 writes (addr 0..3), overflow=1, word_count=4.
REQ-029 reset_n=0 during LOAD after 1 entry pushed -> all outputs at reset values, entry never written.
REQ-030 Second download after RUN -> loaded=0, overflow cleared, writes restart at address 0.
